// File: rtl/data_cache_controller.sv
// data_cache_controller: direct-mapped, write-through, no-write-allocate data cache between MEM stage and SRAM controller
// Ports: clk, rst (async, active-high); mem_rd_en/mem_wr_en/mem_address/mem_write_data in, mem_read_data/mem_ready out
//   (mem_ready=0 freezes the pipeline); sram_rd_en/sram_wr_en/sram_address/sram_write_data out, sram_read_data/sram_ready in.
// `define DATA_CACHE_STATS_EN adds hit_count/miss_count outputs.
module data_cache_controller #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam logic [1:0] IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2;
    localparam int LINES = 2 ** INDEX_BITS;
    logic [1:0]            state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_ram [LINES];
    logic [31:0]           data_ram [LINES];
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit, rd_req, fill, wr_upd, idle;
    logic                  unused_byte_offset;
    assign index              = mem_address[INDEX_BITS+1:2];
    assign tag                = mem_address[31:INDEX_BITS+2];
    assign unused_byte_offset = ^mem_address[1:0];
    assign hit                = valid_q[index] && tag_ram[index] == tag;
    assign idle               = state_q == IDLE;
    assign rd_req             = mem_rd_en && !mem_wr_en;
    assign fill               = state_q == RD_MISS && sram_ready;
    assign wr_upd             = state_q == WR_THRU && sram_ready && hit;
    assign sram_rd_en         = state_q == RD_MISS;
    assign sram_wr_en         = state_q == WR_THRU;
    assign sram_address       = mem_address;
    assign sram_write_data    = mem_write_data;
    // Miss data is bypassed straight from SRAM on its ready cycle
    assign mem_read_data      = fill ? sram_read_data : data_ram[index];
    assign mem_ready          = idle ? !(mem_wr_en || (mem_rd_en && !hit)) : sram_ready;
    always_comb begin
        state_d = idle ? (mem_wr_en ? WR_THRU : (rd_req && !hit) ? RD_MISS : IDLE)
                       : (sram_ready ? IDLE : state_q);
        valid_d = valid_q;
        if (fill) valid_d[index] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end
    // Tag/data need no reset: valid gates them, and reset forces IDLE so an aborted miss never fills
    always_ff @(posedge clk) begin
        if (fill) begin
            data_ram[index] <= sram_read_data;
            tag_ram[index]  <= tag;
        end else if (wr_upd) begin
            data_ram[index] <= mem_write_data;
        end
    end
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, idle && rd_req && hit};
        miss_count_d = miss_count_q + {31'd0, idle && rd_req && !hit};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller: directed tests of data_cache_controller against a 5-cycle SRAM controller model
module tb_data_cache_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0;
    logic [31:0] mem_address = '0, mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        sram_rd_en, sram_wr_en, sram_ready;
    logic [31:0] sram_address, sram_write_data, sram_read_data;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif
    int compared = 0;
    int mismatched = 0;
    int stall, rd_cyc, wr_cyc;
    bit both_seen;
    logic [31:0] rdata;

    data_cache_controller dut (
        .clk(clk), .rst(rst),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_ready(sram_ready)
`ifdef DATA_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // SRAM controller model: ready on the 5th consecutive enabled cycle
    logic [31:0]   sram_mem [0:1023];
    logic [1023:0] sram_written;
    int            sram_cnt;
    function automatic logic [31:0] default_word(input logic [31:0] a);
        return (a == 32'h0000_0410) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction
    assign sram_ready     = (sram_rd_en || sram_wr_en) && sram_cnt == 4;
    assign sram_read_data = sram_written[sram_address[11:2]] ? sram_mem[sram_address[11:2]] : default_word(sram_address);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_cnt     <= 0;
            sram_written <= '0;
        end else begin
            sram_cnt <= ((sram_rd_en || sram_wr_en) && !sram_ready) ? sram_cnt + 1 : 0;
            if (sram_wr_en && sram_ready) begin
                sram_mem[sram_address[11:2]]     <= sram_write_data;
                sram_written[sram_address[11:2]] <= 1'b1;
            end
        end
    end

    // Drive one request from a negedge until mem_ready, measuring stall and enable cycles
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit done = 0;
        stall = 0; rd_cyc = 0; wr_cyc = 0; both_seen = 0; rdata = 'x;
        mem_rd_en = rd; mem_wr_en = wr; mem_address = addr; mem_write_data = wdata;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (sram_rd_en) rd_cyc++;
            if (sram_wr_en) wr_cyc++;
            if (sram_rd_en && sram_wr_en) both_seen = 1;
            if (mem_ready) begin
                rdata = mem_read_data;
                done = 1;
                break;
            end
            stall++;
            @(negedge clk);
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL access_timeout addr=%h: mem_ready never rose within 20 cycles", addr);
        end
        @(negedge clk);
        mem_rd_en = 0; mem_wr_en = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        compared += 3;
        if (mem_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", mem_ready); end
        if (sram_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_sram_rd got %b want 0", sram_rd_en); end
        if (sram_wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_sram_wr got %b want 0", sram_wr_en); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_read_miss;
        access(1, 0, 32'h0000_0410, 0);
        compared += 4;
        if (stall !== 5) begin mismatched++; $display("FAIL miss_stall got %0d want 5", stall); end
        if (rd_cyc !== 5) begin mismatched++; $display("FAIL miss_rd_cycles got %0d want 5", rd_cyc); end
        if (wr_cyc !== 0) begin mismatched++; $display("FAIL miss_wr_cycles got %0d want 0", wr_cyc); end
        if (rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL miss_data got %h want deadbeef", rdata); end
    endtask

    task automatic test_back_to_back;
        access(1, 0, 32'h0000_0410, 0);
        compared += 3;
        if (stall !== 0) begin mismatched++; $display("FAIL hit_stall got %0d want 0", stall); end
        if (rd_cyc !== 0) begin mismatched++; $display("FAIL hit_rd_cycles got %0d want 0", rd_cyc); end
        if (rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL hit_data got %h want deadbeef", rdata); end
`ifdef DATA_CACHE_STATS_EN
        compared += 2;
        if (hit_count !== 32'd1) begin mismatched++; $display("FAIL hit_count got %0d want 1", hit_count); end
        if (miss_count !== 32'd1) begin mismatched++; $display("FAIL miss_count got %0d want 1", miss_count); end
`endif
    endtask

    task automatic test_write_through;
        access(0, 1, 32'h0000_0410, 32'h1234_5678);
        compared += 3;
        if (stall !== 5) begin mismatched++; $display("FAIL wr_hit_stall got %0d want 5", stall); end
        if (wr_cyc !== 5) begin mismatched++; $display("FAIL wr_hit_wr_cycles got %0d want 5", wr_cyc); end
        if (rd_cyc !== 0) begin mismatched++; $display("FAIL wr_hit_rd_cycles got %0d want 0", rd_cyc); end
        access(1, 0, 32'h0000_0410, 0);
        compared += 2;
        if (stall !== 0) begin mismatched++; $display("FAIL wr_hit_reread_stall got %0d want 0", stall); end
        if (rdata !== 32'h1234_5678) begin mismatched++; $display("FAIL wr_hit_reread_data got %h want 12345678", rdata); end
        access(0, 1, 32'h0000_0420, 32'hCAFE_F00D);
        compared++;
        if (wr_cyc !== 5) begin mismatched++; $display("FAIL wr_miss_wr_cycles got %0d want 5", wr_cyc); end
        access(1, 0, 32'h0000_0420, 0);
        compared += 2;
        if (stall !== 5) begin mismatched++; $display("FAIL no_alloc_stall got %0d want 5", stall); end
        if (rdata !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL no_alloc_data got %h want cafef00d", rdata); end
        access(1, 0, 32'h0000_0420, 0);
        compared++;
        if (stall !== 0) begin mismatched++; $display("FAIL filled_420_stall got %0d want 0", stall); end
    endtask

    task automatic test_conflict;
        access(1, 0, 32'h0000_0510, 0);
        compared += 2;
        if (stall !== 5) begin mismatched++; $display("FAIL conflict_stall got %0d want 5", stall); end
        if (rdata !== 32'hA5A5_0510) begin mismatched++; $display("FAIL conflict_data got %h want a5a50510", rdata); end
        access(1, 0, 32'h0000_0410, 0);
        compared += 2;
        if (stall !== 5) begin mismatched++; $display("FAIL evicted_stall got %0d want 5", stall); end
        if (rdata !== 32'h1234_5678) begin mismatched++; $display("FAIL evicted_data got %h want 12345678", rdata); end
    endtask

    task automatic test_reset_mid_miss;
        mem_rd_en = 1; mem_wr_en = 0; mem_address = 32'h0000_0600;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (sram_rd_en !== 1'b1) begin mismatched++; $display("FAIL midmiss_rd_en got %b want 1", sram_rd_en); end
        rst = 1;
        #1;
        compared += 2;
        if (sram_rd_en !== 1'b0) begin mismatched++; $display("FAIL async_rst_rd_en got %b want 0", sram_rd_en); end
        if (mem_ready !== 1'b0) begin mismatched++; $display("FAIL rst_pending_ready got %b want 0", mem_ready); end
        mem_rd_en = 0;
        #1;
        compared++;
        if (mem_ready !== 1'b1) begin mismatched++; $display("FAIL rst_idle_ready got %b want 1", mem_ready); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        access(1, 0, 32'h0000_0600, 0);
        compared += 2;
        if (stall !== 5) begin mismatched++; $display("FAIL aborted_no_fill_stall got %0d want 5", stall); end
        if (rdata !== 32'hA5A5_0600) begin mismatched++; $display("FAIL aborted_refill_data got %h want a5a50600", rdata); end
        access(1, 0, 32'h0000_0410, 0);
        compared++;
        if (stall !== 5) begin mismatched++; $display("FAIL rst_invalidates_stall got %0d want 5", stall); end
    endtask

    task automatic test_both_enables;
        access(1, 1, 32'h0000_0410, 32'h0BAD_CAFE);
        compared += 3;
        if (wr_cyc !== 5) begin mismatched++; $display("FAIL both_wr_cycles got %0d want 5", wr_cyc); end
        if (rd_cyc !== 0) begin mismatched++; $display("FAIL both_rd_cycles got %0d want 0", rd_cyc); end
        if (both_seen !== 1'b0) begin mismatched++; $display("FAIL both_enables_high got %b want 0", both_seen); end
        access(1, 0, 32'h0000_0410, 0);
        compared += 2;
        if (stall !== 0) begin mismatched++; $display("FAIL both_reread_stall got %0d want 0", stall); end
        if (rdata !== 32'h0BAD_CAFE) begin mismatched++; $display("FAIL both_reread_data got %h want 0badcafe", rdata); end
    endtask

    initial begin
        test_reset;
        test_read_miss;
        test_back_to_back;
        test_write_through;
        test_conflict;
        test_reset_mid_miss;
        test_both_enables;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
